// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register: reset PC and exception codes.
// Stage registers import these so every stage agrees on reset/flush values.
package pipe_stage_reg_pkg;

  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: flush > hold > bubble > load, one-cycle latency.
// A bubble keeps in_pc/in_bd so a later exception still reports the right EPC.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter int          TNEW_W   = 2,
  parameter int          TNEW_DEC = 1,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] PC_RST   = INITIAL_ADDRESS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              bubble,
  input  logic              cnt_clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_a3,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [4:0]        in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_a3,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [4:0]        out_exc,
  output logic              out_bd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic take_bubble;

  assign take_bubble = bubble && !hold && !flush;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_instr <= '0;
      out_pc    <= PC_RST;
      out_a3    <= '0;
      out_tnew  <= '0;
      out_exc   <= EXC_NONE;
      out_bd    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_instr <= '0;
      out_pc    <= PC_RST;
      out_a3    <= '0;
      out_tnew  <= '0;
      out_exc   <= EXC_NONE;
      out_bd    <= 1'b0;
    end else if (hold) begin
      out_valid <= out_valid;
    end else if (bubble) begin
      // a3 forced to zero so hazard logic never forwards from a bubble
      out_valid <= 1'b0;
      out_data  <= '0;
      out_instr <= '0;
      out_pc    <= in_pc;
      out_a3    <= '0;
      out_tnew  <= '0;
      out_exc   <= EXC_NONE;
      out_bd    <= in_bd;
    end else begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      out_a3    <= in_a3;
      out_tnew  <= (TNEW_DEC != 0) ? sat_dec(in_tnew) : in_tnew;
      out_exc   <= in_exc;
      out_bd    <= in_bd;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (take_bubble),
    .clr   (cnt_clr),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, load/Tnew, hold, bubble, priority
// conflicts, and bubble counter saturation on a narrow-counter instance.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        hold, flush, bubble, cnt_clr;
  logic [63:0] in_data;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  in_a3, in_exc;
  logic [1:0]  in_tnew;
  logic        in_bd;

  logic        out_valid;
  logic [63:0] out_data;
  logic [31:0] out_instr, out_pc;
  logic [4:0]  out_a3, out_exc;
  logic [1:0]  out_tnew;
  logic        out_bd;
  logic [15:0] bubble_cnt;

  logic        bubble_b, clr_b;
  logic        b_valid;
  logic [63:0] b_data;
  logic [31:0] b_instr, b_pc;
  logic [4:0]  b_a3, b_exc;
  logic [1:0]  b_tnew;
  logic        b_bd;
  logic [1:0]  b_cnt;

  int errors;
  int checks;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .bubble(bubble),
    .cnt_clr(cnt_clr), .in_data(in_data), .in_instr(in_instr), .in_pc(in_pc),
    .in_a3(in_a3), .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_data(out_data), .out_instr(out_instr),
    .out_pc(out_pc), .out_a3(out_a3), .out_tnew(out_tnew), .out_exc(out_exc),
    .out_bd(out_bd), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_narrow (
    .clk(clk), .reset(reset), .hold(1'b0), .flush(1'b0), .bubble(bubble_b),
    .cnt_clr(clr_b), .in_data(in_data), .in_instr(in_instr), .in_pc(in_pc),
    .in_a3(in_a3), .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(b_valid), .out_data(b_data), .out_instr(b_instr),
    .out_pc(b_pc), .out_a3(b_a3), .out_tnew(b_tnew), .out_exc(b_exc),
    .out_bd(b_bd), .bubble_cnt(b_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] a3,
                        input logic [1:0] tnew, input logic bd);
    in_pc    = pc;
    in_a3    = a3;
    in_tnew  = tnew;
    in_bd    = bd;
    in_instr = {pc[15:0], 11'd0, a3};
    in_data  = {pc, ~pc};
    in_exc   = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stage(input string tag, input logic valid,
                             input logic [31:0] pc, input logic [4:0] a3,
                             input logic [1:0] tnew, input logic bd,
                             input logic [15:0] cnt);
    check({tag, ".valid"}, 64'(out_valid), 64'(valid));
    check({tag, ".pc"},    64'(out_pc),    64'(pc));
    check({tag, ".a3"},    64'(out_a3),    64'(a3));
    check({tag, ".tnew"},  64'(out_tnew),  64'(tnew));
    check({tag, ".bd"},    64'(out_bd),    64'(bd));
    check({tag, ".cnt"},   64'(bubble_cnt), 64'(cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    hold = 1'b0; flush = 1'b0; bubble = 1'b0; cnt_clr = 1'b0;
    bubble_b = 1'b0; clr_b = 1'b0;
    set_in(32'h0, 5'd0, 2'd0, 1'b0);

    // asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    check_stage("reset", 1'b0, 32'h3000, 5'd0, 2'd0, 1'b0, 16'd0);
    check("reset.data", out_data, 64'd0);
    check("reset.narrow_cnt", 64'(b_cnt), 64'd0);
    tick();
    reset = 1'b1;

    // load with Tnew decrement
    set_in(32'h3004, 5'd5, 2'd2, 1'b0);
    tick();
    check_stage("load_t2", 1'b1, 32'h3004, 5'd5, 2'd1, 1'b0, 16'd0);
    check("load_t2.data", out_data, {32'h3004, ~32'h3004});
    check("load_t2.instr", 64'(out_instr), 64'({16'h3004, 11'd0, 5'd5}));

    set_in(32'h3008, 5'd6, 2'd0, 1'b1);
    tick();
    check_stage("load_t0", 1'b1, 32'h3008, 5'd6, 2'd0, 1'b1, 16'd0);

    set_in(32'h300c, 5'd9, 2'd3, 1'b0);
    in_exc = 5'd12;
    tick();
    check_stage("load_t3", 1'b1, 32'h300c, 5'd9, 2'd2, 1'b0, 16'd0);
    check("load_t3.exc", 64'(out_exc), 64'd12);

    // hold for three cycles with changing inputs; second cycle also bubbles
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h4000 + 32'(i * 4), 5'(i + 20), 2'(i), 1'b1);
      bubble = (i == 1);
      tick();
      check_stage($sformatf("hold%0d", i), 1'b1, 32'h300c, 5'd9, 2'd2, 1'b0, 16'd0);
      check($sformatf("hold%0d.exc", i), 64'(out_exc), 64'd12);
    end
    hold = 1'b0;
    bubble = 1'b0;

    // bubble keeps pc/bd, zeroes the rest, counts
    set_in(32'h3010, 5'd7, 2'd3, 1'b1);
    bubble = 1'b1;
    tick();
    check_stage("bubble1", 1'b0, 32'h3010, 5'd0, 2'd0, 1'b1, 16'd1);
    check("bubble1.data", out_data, 64'd0);
    check("bubble1.exc", 64'(out_exc), 64'd0);

    set_in(32'h3014, 5'd8, 2'd1, 1'b0);
    tick();
    check_stage("bubble2", 1'b0, 32'h3014, 5'd0, 2'd0, 1'b0, 16'd2);

    // flush + hold + bubble: flush wins, no count
    flush = 1'b1;
    hold = 1'b1;
    set_in(32'h3018, 5'd3, 2'd2, 1'b1);
    tick();
    check_stage("flush_all", 1'b0, 32'h3000, 5'd0, 2'd0, 1'b0, 16'd2);
    flush = 1'b0;
    hold = 1'b0;

    // cnt_clr with a bubble edge: clear wins, bubble still taken
    cnt_clr = 1'b1;
    set_in(32'h301c, 5'd4, 2'd1, 1'b1);
    tick();
    check_stage("clr_bubble", 1'b0, 32'h301c, 5'd0, 2'd0, 1'b1, 16'd0);
    cnt_clr = 1'b0;

    // one more bubble, then cnt_clr while held
    tick();
    check("rebubble.cnt", 64'(bubble_cnt), 64'd1);
    bubble = 1'b0;
    hold = 1'b1;
    cnt_clr = 1'b1;
    set_in(32'h5000, 5'd11, 2'd2, 1'b0);
    tick();
    check_stage("hold_clr", 1'b0, 32'h301c, 5'd0, 2'd0, 1'b1, 16'd0);
    hold = 1'b0;
    cnt_clr = 1'b0;

    // narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      bubble_b = 1'b1;
      tick();
      check($sformatf("narrow_sat%0d", i), 64'(b_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    clr_b = 1'b1;
    tick();
    check("narrow_clr", 64'(b_cnt), 64'd0);
    check("narrow_clr.valid", 64'(b_valid), 64'd0);
    clr_b = 1'b0;
    bubble_b = 1'b0;

    // load, then asynchronous reset mid-stall/flush
    set_in(32'h3020, 5'd13, 2'd2, 1'b1);
    tick();
    check_stage("preload", 1'b1, 32'h3020, 5'd13, 2'd1, 1'b1, 16'd0);
    bubble = 1'b1;
    tick();
    bubble = 1'b0;
    hold = 1'b1;
    flush = 1'b1;
    reset = 1'b0;
    #1;
    check_stage("midreset", 1'b0, 32'h3000, 5'd0, 2'd0, 1'b0, 16'd0);
    check("midreset.data", out_data, 64'd0);
    tick();
    reset = 1'b1;
    hold = 1'b0;
    flush = 1'b0;

    // first edge after reset behaves normally
    set_in(32'h3024, 5'd14, 2'd1, 1'b0);
    tick();
    check_stage("post_reset", 1'b1, 32'h3024, 5'd14, 2'd0, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
